seq_mem_req_sequencer: RTL and testbench

SEQ_MEM_REQ_SEQUENCER -- requirements
Module: seq_mem_req_sequencer

---
 rtl/seq_mem_req_sequencer.sv | 144 ++++++++++++++
 tb/tb_seq_mem_req_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mem_req_sequencer.sv
// Single-outstanding request sequencer between a valid/ready command port
// and a simple enable/done memory port. Each accepted command is range
// checked, issued to memory for exactly one cycle, waited on with a bounded
// timeout and answered with one response on a valid/ready response port.
module seq_mem_req_sequencer #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 1,
  parameter int IDX_SIZE = 2,
  parameter int TIMEOUT  = 8
) (
  input  logic                clk,
  input  logic                reset,
  // upstream command port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [IDX_SIZE-1:0] cmd_addr,
  input  logic [WIDTH-1:0]    cmd_data,
  // downstream response port
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_data,
  output logic                rsp_err,
  // memory port
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic [WIDTH-1:0]    mem_in,
  output logic                mem_read_en,
  output logic                mem_write_en,
  input  logic [WIDTH-1:0]    mem_out,
  input  logic                mem_read_done,
  input  logic                mem_write_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // TIMEOUT is limited to 1..255, so an 8-bit wait counter always suffices.
  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);

  // When SIZE covers every encodable address no range check is needed;
  // otherwise compare against SIZE with one spare bit so SIZE == 2**IDX_SIZE
  // style values never truncate.
  localparam int                ADDR_SPAN    = 1 << IDX_SIZE;
  localparam bit                ALL_IN_RANGE = (SIZE >= ADDR_SPAN);
  localparam logic [IDX_SIZE:0] SIZE_CUT     = ALL_IN_RANGE ? '0 : (IDX_SIZE+1)'(SIZE);

  state_t     state;
  logic       write_reg;   // direction of the request currently in flight
  logic [7:0] wait_count;  // 1-based count of cycles spent in WAIT
  logic       addr_in_range;
  logic       done_match;

  assign addr_in_range = ALL_IN_RANGE || ({1'b0, cmd_addr} < SIZE_CUT);

  // Only the done line that matches the in-flight direction can finish WAIT.
  assign done_match = write_reg ? mem_write_done : mem_read_done;

  // Handshake flags are pure decodes of the state register.
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Sequencer FSM together with all of its registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      write_reg    <= 1'b0;
      wait_count   <= 8'd0;
      mem_addr0    <= '0;
      mem_in       <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      // Enables are single-cycle strobes; they are only set on the
      // IDLE->ISSUE transition, so they fall again when ISSUE ends.
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;

      case (state)
        IDLE: begin
          wait_count <= 8'd0;
          if (cmd_valid) begin
            // Address and data stay on the memory port until the next
            // accepted command, even for rejected addresses.
            write_reg <= cmd_write;
            mem_addr0 <= cmd_addr;
            mem_in    <= cmd_data;
            if (addr_in_range) begin
              state        <= ISSUE;
              mem_read_en  <= ~cmd_write;
              mem_write_en <= cmd_write;
            end else begin
              // Out-of-range: answer immediately, memory is never touched.
              state    <= RESP;
              rsp_err  <= 1'b1;
              rsp_data <= '0;
            end
          end
        end

        ISSUE: begin
          // The enable strobe is visible during this cycle only.
          state      <= WAIT;
          wait_count <= 8'd1;
        end

        WAIT: begin
          // A matching done on the last allowed cycle still counts as success.
          if (done_match) begin
            state    <= RESP;
            rsp_err  <= 1'b0;
            rsp_data <= write_reg ? '0 : mem_out;
          end else if (wait_count >= TIMEOUT_VAL) begin
            state    <= RESP;
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end else begin
            wait_count <= wait_count + 8'd1;
          end
        end

        RESP: begin
          // Response fields are frozen until downstream takes them; the
          // command port reopens only in the following cycle.
          if (rsp_ready) begin
            state    <= IDLE;
            rsp_err  <= 1'b0;
            rsp_data <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mem_req_sequencer.sv
// Randomized self-checking bench for seq_mem_req_sequencer. The bench plays
// the memory (a small array that reacts to the enable strobes) and predicts
// every response from the request rules: range check, done delay against
// the timeout, and a shadow copy of the memory contents.
module tb_seq_mem_req_sequencer;

  localparam int WIDTH    = 32;
  localparam int SIZE     = 2;
  localparam int IDX_SIZE = 2;
  localparam int TIMEOUT  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [IDX_SIZE-1:0] cmd_addr;
  logic [WIDTH-1:0]    cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WIDTH-1:0]    rsp_data;
  logic                rsp_err;
  logic [IDX_SIZE-1:0] mem_addr0;
  logic [WIDTH-1:0]    mem_in;
  logic                mem_read_en;
  logic                mem_write_en;
  logic [WIDTH-1:0]    mem_out;
  logic                mem_read_done;
  logic                mem_write_done;

  int checks   = 0;
  int failures = 0;

  // Memory device driven purely by the DUT's memory pins.
  logic [WIDTH-1:0] dev [0:3] = '{default: '0};
  logic [WIDTH-1:0] rd_latch  = '0;
  // Expected memory contents, updated from the transaction list.
  logic [WIDTH-1:0] exp_mem [0:3] = '{default: '0};

  seq_mem_req_sequencer #(
    .WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX_SIZE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .mem_addr0(mem_addr0), .mem_in(mem_in), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_out(mem_out),
    .mem_read_done(mem_read_done), .mem_write_done(mem_write_done)
  );

  always #5 clk = ~clk;

  // Memory device: writes and read captures happen on the enable strobe.
  always @(posedge clk) begin
    if (mem_write_en) dev[mem_addr0] <= mem_in;
    if (mem_read_en)  rd_latch <= dev[mem_addr0];
  end
  assign mem_out = rd_latch;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One complete request/response exchange; called and returns on a negedge.
  task automatic run_txn(input bit wr, input logic [1:0] addr, input logic [31:0] data,
                         input int delay, input int hold, input bit pre_pulse, input bit stray);
    bit          in_rng;
    int          exp_first;
    int          got_first;
    bit          exp_err;
    logic [31:0] exp_data;
    logic [31:0] got_data;
    logic        got_err;
    in_rng = (int'(addr) < SIZE);
    if (!in_rng) begin
      exp_first = 1; exp_err = 1'b1; exp_data = '0;
    end else if (delay <= TIMEOUT) begin
      exp_first = 2 + delay; exp_err = 1'b0; exp_data = wr ? 32'h0 : exp_mem[addr];
    end else begin
      exp_first = 2 + TIMEOUT; exp_err = 1'b1; exp_data = '0;
    end
    if (in_rng && wr) exp_mem[addr] = data;

    check_val("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_data = data;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 2'($urandom);
    cmd_data  = $urandom;

    got_first = 0;
    for (int k = 1; k <= TIMEOUT + 4; k++) begin
      if (k == 1) begin
        check_val("mem_addr0", mem_addr0, addr);
        check_val("mem_in", mem_in, data);
      end
      check_val("rd_en", mem_read_en, in_rng && !wr && k == 1);
      check_val("wr_en", mem_write_en, in_rng && wr && k == 1);
      check_val("en_excl", mem_read_en && mem_write_en, 1'b0);
      if (rsp_valid) begin
        got_first = k;
        break;
      end
      check_val("cmd_ready_busy", cmd_ready, 1'b0);
      // Matching done on WAIT cycle 'delay'; optional early pulse during
      // ISSUE and random pulses on the other line must be ignored.
      mem_read_done  = !wr && ((k == 1 + delay) || (pre_pulse && k == 1));
      mem_write_done =  wr && ((k == 1 + delay) || (pre_pulse && k == 1));
      if (stray) begin
        if (wr) mem_read_done  = 1'($urandom);
        else    mem_write_done = 1'($urandom);
      end
      @(negedge clk);
    end
    mem_read_done  = 1'b0;
    mem_write_done = 1'b0;

    check_val("latency", got_first, exp_first);
    got_data = rsp_data;
    got_err  = rsp_err;
    if (got_first != 0) begin
      check_val("rsp_err", rsp_err, exp_err);
      check_val("rsp_data", rsp_data, exp_data);
      for (int h = 0; h < hold; h++) begin
        mem_read_done  = 1'($urandom);
        mem_write_done = 1'($urandom);
        @(negedge clk);
        check_val("hold_valid", rsp_valid, 1'b1);
        check_val("hold_err", rsp_err, exp_err);
        check_val("hold_data", rsp_data, exp_data);
        check_val("hold_ready", cmd_ready, 1'b0);
      end
      mem_read_done  = 1'b0;
      mem_write_done = 1'b0;
      // Offer a command during the response handshake; it must not be taken.
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd3;
      @(negedge clk);
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      check_val("rsp_drop", rsp_valid, 1'b0);
      check_val("cmd_ready_back", cmd_ready, 1'b1);
    end
    $display("txn wr=%0d addr=%0d data=%08h delay=%0d hold=%0d latency=%0d err=%0b rdata=%08h",
             wr, addr, data, delay, hold, got_first, got_err, got_data);
  endtask

  // Start an in-range read that never gets acked and reset it at step at_k.
  task automatic reset_mid(input int at_k);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd1; cmd_data = 32'hA5A5_0F0F;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k < at_k; k++) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("rst_rd_en", mem_read_en, 1'b0);
    check_val("rst_wr_en", mem_write_en, 1'b0);
    check_val("rst_rsp_valid", rsp_valid, 1'b0);
    check_val("rst_rsp_err", rsp_err, 1'b0);
    check_val("rst_rsp_data", rsp_data, 32'h0);
    check_val("rst_addr", mem_addr0, 2'd0);
    check_val("rst_mem_in", mem_in, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    mem_read_done = 1'b1;
    @(negedge clk);
    mem_read_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val("late_done_valid", rsp_valid, 1'b0);
      check_val("late_done_ready", cmd_ready, 1'b1);
      check_val("late_done_en", mem_read_en, 1'b0);
      @(negedge clk);
    end
    $display("txn reset_mid step=%0d", at_k);
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b0; mem_read_done = 1'b0; mem_write_done = 1'b0;
    #1;
    check_val("init_rsp_valid", rsp_valid, 1'b0);
    check_val("init_rsp_err", rsp_err, 1'b0);
    check_val("init_rsp_data", rsp_data, 32'h0);
    check_val("init_rd_en", mem_read_en, 1'b0);
    check_val("init_wr_en", mem_write_en, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_val("init_cmd_ready", cmd_ready, 1'b1);

    // Directed: write/read, out-of-range, timeout edges, back-pressure.
    run_txn(1'b1, 2'd0, 32'hDEADBEEF, 1, 0, 1'b0, 1'b0);
    run_txn(1'b0, 2'd0, 32'h0, 1, 0, 1'b0, 1'b0);
    run_txn(1'b0, 2'd2, 32'h1234_5678, 1, 0, 1'b0, 1'b0);
    run_txn(1'b0, 2'd0, 32'h0, TIMEOUT + 2, 0, 1'b0, 1'b0);
    run_txn(1'b0, 2'd0, 32'h0, TIMEOUT, 0, 1'b0, 1'b0);
    run_txn(1'b1, 2'd1, 32'hCAFE_F00D, TIMEOUT, 0, 1'b1, 1'b1);
    run_txn(1'b0, 2'd1, 32'h0, 2, 5, 1'b0, 1'b1);
    reset_mid(3);
    reset_mid(1);
    reset_mid(2 + TIMEOUT);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      run_txn(1'($urandom), 2'($urandom), $urandom, $urandom_range(1, TIMEOUT + 2),
              $urandom_range(0, 5), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
